// File: rtl/bcd_sa0_test_ctrl.sv
// Stuck-at-0 self-test sequencer for a BCD-to-excess-3 converter; build with FIRST_FAIL_EN to capture the first failing code.
// Latency: (LAST_CODE+1)*(SETTLE_CYC+2)+1 cycles from accepted start to done; each vector takes SETTLE_CYC+2 cycles.
// Backpressure: none; start is honoured only in IDLE, and abort returns to IDLE from any busy state.
module bcd_sa0_test_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LAST_CODE  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] din_o,
    input  logic [3:0] q_i,
    output logic       busy,
    output logic       done,
    output logic [3:0] sa0_mask,
    output logic       other_err,
    output logic [3:0] err_cnt,
    output logic       pass,
    output logic [3:0] fail_code,
    output logic       fail_valid
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] LAST   = 4'(LAST_CODE);
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] mask_q, mask_d;
    logic       oerr_q, oerr_d;
    logic [3:0] errc_q, errc_d;
    logic       pass_q, pass_d;
    logic [3:0] exp_code;
    logic       mism;
`ifdef FIRST_FAIL_EN
    logic [3:0] fcode_q, fcode_d;
    logic       fvld_q, fvld_d;
`endif

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        mask_d   = mask_q;
        oerr_d   = oerr_q;
        errc_d   = errc_q;
        pass_d   = pass_q;
`ifdef FIRST_FAIL_EN
        fcode_d  = fcode_q;
        fvld_d   = fvld_q;
`endif
        exp_code = code_q + 4'd3;
        mism     = (q_i != exp_code);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_APPLY;
                    code_d  = 4'd0;
                    mask_d  = 4'd0;
                    oerr_d  = 1'b0;
                    errc_d  = 4'd0;
                    pass_d  = 1'b0;
`ifdef FIRST_FAIL_EN
                    fcode_d = 4'd0;
                    fvld_d  = 1'b0;
`endif
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = SETTLE;
                    state_d = (SETTLE == 4'd0) ? S_CHECK : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    mask_d = mask_q | (exp_code & ~q_i);
                    oerr_d = oerr_q | (|(~exp_code & q_i));
                    if (mism && errc_q != 4'd15) errc_d = errc_q + 4'd1;
`ifdef FIRST_FAIL_EN
                    if (mism && !fvld_q) begin
                        fcode_d = code_q;
                        fvld_d  = 1'b1;
                    end
`endif
                    if (code_q == LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (errc_d == 4'd0);
                    end else begin
                        code_d  = code_q + 4'd1;
                        state_d = S_APPLY;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= 4'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= 4'd0;
            oerr_q  <= 1'b0;
            errc_q  <= 4'd0;
            pass_q  <= 1'b0;
`ifdef FIRST_FAIL_EN
            fcode_q <= 4'd0;
            fvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            oerr_q  <= oerr_d;
            errc_q  <= errc_d;
            pass_q  <= pass_d;
`ifdef FIRST_FAIL_EN
            fcode_q <= fcode_d;
            fvld_q  <= fvld_d;
`endif
        end
    end

    assign din_o     = code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sa0_mask  = mask_q;
    assign other_err = oerr_q;
    assign err_cnt   = errc_q;
    assign pass      = pass_q;
`ifdef FIRST_FAIL_EN
    assign fail_code  = fcode_q;
    assign fail_valid = fvld_q;
`else
    assign fail_code  = 4'd0;
    assign fail_valid = 1'b0;
`endif
endmodule
